// File: rtl/uart_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module : uart_pattern_loader
// Brief  : 8N1 UART receiver plus framed loader writing 5-bit LED patterns.
// Rev    : 1.0
// ============================================================================
module uart_pattern_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DEPTH        = 436,
  parameter int ADDR_W       = 9,
  parameter int TIMEOUT_BITS = 20,
  parameter int LAST_RST     = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rxd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [4:0]        mem_wdata,
  output logic [ADDR_W-1:0] pat_last,
  output logic              load_done,
  output logic              load_err
);

  localparam int c_CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int c_TIMEOUT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int c_TO_W    = $clog2(c_TIMEOUT + 1);

  localparam logic [c_CNT_W-1:0] c_HALF      = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_TO_W-1:0]  c_TO_FIRE   = c_TO_W'(c_TIMEOUT - 1);
  localparam logic [c_TO_W-1:0]  c_TO_MAX    = c_TO_W'(c_TIMEOUT);
  localparam logic [7:0]         c_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    P_SYNC = 2'd0,
    P_LEN  = 2'd1,
    P_DATA = 2'd2,
    P_SUM  = 2'd3
  } p_state_t;

  logic               r_rx_meta;
  logic               r_rx_sync;
  logic               r_rx_prev;
  rx_state_t          r_rx_state;
  logic [c_CNT_W-1:0] r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_rx_shift;
  logic               r_byte_valid;
  logic               r_frame_err;

  p_state_t           r_p_state;
  logic [ADDR_W-1:0]  r_idx;
  logic [ADDR_W-1:0]  r_last;
  logic [7:0]         r_xor;
  logic [c_TO_W-1:0]  r_to_cnt;

  logic               w_timeout;
  logic               w_len_bad;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Bit timing: start bit re-checked at half a bit, data and stop at bit centre.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_state   <= RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_rx_shift   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_clk_cnt == c_HALF) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == c_FULL) begin
            r_clk_cnt  <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_bit_idx  <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
              r_rx_state <= RX_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == c_FULL) begin
            r_clk_cnt    <= '0;
            r_byte_valid <= r_rx_sync;
            r_frame_err  <= ~r_rx_sync;
            r_rx_state   <= RX_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Gap counter only runs inside a frame; firing one cycle early lines the
  // registered load_err up with timeout+1 cycles after the last byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_to_cnt <= '0;
    end else if (r_byte_valid || (r_p_state == P_SYNC)) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != c_TO_MAX) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_p_state != P_SYNC) && !r_byte_valid && (r_to_cnt == c_TO_FIRE);
  assign w_len_bad = (r_rx_shift == 8'd0) || (32'(r_rx_shift) > DEPTH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_p_state <= P_SYNC;
      r_idx     <= '0;
      r_last    <= '0;
      r_xor     <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      pat_last  <= ADDR_W'(LAST_RST);
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      if ((r_frame_err && (r_p_state != P_SYNC)) || w_timeout) begin
        load_err  <= 1'b1;
        r_p_state <= P_SYNC;
      end else if (r_byte_valid) begin
        case (r_p_state)
          P_SYNC: begin
            if (r_rx_shift == c_SYNC_BYTE) begin
              r_p_state <= P_LEN;
            end
          end
          P_LEN: begin
            if (w_len_bad) begin
              load_err  <= 1'b1;
              r_p_state <= P_SYNC;
            end else begin
              r_idx     <= '0;
              r_xor     <= '0;
              r_last    <= ADDR_W'(r_rx_shift - 8'd1);
              r_p_state <= P_DATA;
            end
          end
          P_DATA: begin
            mem_we    <= 1'b1;
            mem_waddr <= r_idx;
            mem_wdata <= r_rx_shift[4:0];
            r_xor     <= r_xor ^ r_rx_shift;
            r_idx     <= r_idx + 1'b1;
            if (r_idx == r_last) begin
              r_p_state <= P_SUM;
            end
          end
          P_SUM: begin
            if (r_rx_shift == r_xor) begin
              pat_last  <= r_last;
              load_done <= 1'b1;
            end else begin
              load_err  <= 1'b1;
            end
            r_p_state <= P_SYNC;
          end
          default: r_p_state <= P_SYNC;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
